// File: rtl/filter_sequencer.sv
// rtl/filter_sequencer.sv - sample sequencer for an external filter with shadowed coefficients
//
// Purpose:
//   Accepts one input sample at a time and presents it to an external filter.
//   It pulses f_en, waits SETTLE cycles, then captures f_y as the result and
//   holds it until the consumer accepts it. Coefficients are written into
//   shadow registers. A commit copies them into the active set atomically on
//   the next sample acceptance.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   run                      level enable for sample acceptance
//   cfg_we/addr/wdata        shadow coefficient write (0=b0 1=b1 2=a0 3=a1 4=a2)
//   cfg_commit               request shadow -> active copy at next accept
//   s_valid/s_data/s_ready   input sample handshake
//   f_en/f_x/f_b0..f_a2      filter drive: enable pulse, sample, active coefficients
//   f_y                      filter output
//   m_valid/m_data/m_ready   result handshake
//   busy                     sequence in flight (FIRE, SETTLE or OUT)
//   drop_cnt                 saturating count of samples offered while busy
module filter_sequencer #(
   parameter int N      = 16,
   parameter int SETTLE = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         run,
   input  logic         cfg_we,
   input  logic [2:0]   cfg_addr,
   input  logic [N-1:0] cfg_wdata,
   input  logic         cfg_commit,
   input  logic         s_valid,
   input  logic [N-1:0] s_data,
   output logic         s_ready,
   output logic         f_en,
   output logic [N-1:0] f_x,
   output logic [N-1:0] f_b0,
   output logic [N-1:0] f_b1,
   output logic [N-1:0] f_a0,
   output logic [N-1:0] f_a1,
   output logic [N-1:0] f_a2,
   input  logic [N-1:0] f_y,
   output logic         m_valid,
   output logic [N-1:0] m_data,
   input  logic         m_ready,
   output logic         busy,
   output logic [7:0]   drop_cnt
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT,
      ST_FIRE,
      ST_SETTLE,
      ST_OUT
   } state_t;

   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

   state_t       state_q, state_d;
   logic [3:0]   cnt_q, cnt_d;
   logic [N-1:0] f_x_q, f_x_d;
   logic [N-1:0] m_data_q, m_data_d;
   logic         m_valid_q, m_valid_d;
   logic         pend_q, pend_d;
   logic [7:0]   drop_q, drop_d;
   logic [N-1:0] shd_q [5];
   logic [N-1:0] shd_d [5];
   logic [N-1:0] act_q [5];
   logic [N-1:0] act_d [5];
   logic         accept;
   logic         busy_st;

   assign busy_st = (state_q == ST_FIRE) || (state_q == ST_SETTLE) || (state_q == ST_OUT);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      f_x_d     = f_x_q;
      m_data_d  = m_data_q;
      m_valid_d = m_valid_q;
      drop_d    = drop_q;
      accept    = 1'b0;
      for (int i = 0; i < 5; i++) begin
         shd_d[i] = shd_q[i];
         act_d[i] = act_q[i];
      end

      case (state_q)
         ST_IDLE: begin
            if (run) state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (s_valid) begin
               accept  = 1'b1;
               f_x_d   = s_data;
               state_d = ST_FIRE;
            end else if (!run) begin
               state_d = ST_IDLE;
            end
         end
         ST_FIRE: begin
            cnt_d   = 4'd0;
            state_d = ST_SETTLE;
         end
         ST_SETTLE: begin
            // Capture on the last settle cycle so m_valid rises SETTLE+1 after f_en.
            if (cnt_q == SETTLE_LAST) begin
               m_data_d  = f_y;
               m_valid_d = 1'b1;
               state_d   = ST_OUT;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         ST_OUT: begin
            if (m_ready) begin
               m_valid_d = 1'b0;
               state_d   = run ? ST_WAIT : ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      for (int i = 0; i < 5; i++) begin
         if (cfg_we && (cfg_addr == 3'(i))) shd_d[i] = cfg_wdata;
      end

      // The active set loads from the pre-edge shadow contents. A write in
      // the same cycle lands in shadow and joins the next commit.
      if (accept && pend_q) begin
         for (int i = 0; i < 5; i++) act_d[i] = shd_q[i];
      end

      // A commit that coincides with an accept is kept pending for the next sample.
      pend_d = (pend_q && !accept) || cfg_commit;

      if (s_valid && run && busy_st && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= ST_IDLE;
         cnt_q     <= 4'd0;
         f_x_q     <= '0;
         m_data_q  <= '0;
         m_valid_q <= 1'b0;
         pend_q    <= 1'b0;
         drop_q    <= 8'd0;
         for (int i = 0; i < 5; i++) begin
            shd_q[i] <= '0;
            act_q[i] <= '0;
         end
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         f_x_q     <= f_x_d;
         m_data_q  <= m_data_d;
         m_valid_q <= m_valid_d;
         pend_q    <= pend_d;
         drop_q    <= drop_d;
         for (int i = 0; i < 5; i++) begin
            shd_q[i] <= shd_d[i];
            act_q[i] <= act_d[i];
         end
      end
   end

   assign s_ready  = (state_q == ST_WAIT);
   assign f_en     = (state_q == ST_FIRE);
   assign busy     = busy_st;
   assign f_x      = f_x_q;
   assign m_valid  = m_valid_q;
   assign m_data   = m_data_q;
   assign drop_cnt = drop_q;
   assign f_b0     = act_q[0];
   assign f_b1     = act_q[1];
   assign f_a0     = act_q[2];
   assign f_a1     = act_q[3];
   assign f_a2     = act_q[4];

endmodule
